// File: rtl/ram_fifo_ctrl_if.sv
// Valid/ready stream bundle between producer, FIFO and consumer.
// The FIFO takes the slave modport; the environment drives the master side.
interface ram_fifo_ctrl_if #(
  parameter int unsigned SIZE = 8
);
  logic [SIZE-1:0] wr_data;
  logic            wr_valid;
  logic            wr_ready;
  logic [SIZE-1:0] rd_data;
  logic            rd_valid;
  logic            rd_ready;

  modport master (
    output wr_data, wr_valid, rd_ready,
    input  wr_ready, rd_data, rd_valid
  );

  modport slave (
    input  wr_data, wr_valid, rd_ready,
    output wr_ready, rd_data, rd_valid
  );
endinterface

// File: rtl/simple_dual_ram.sv
// Simple dual-port RAM: one write port, one registered read port, separate clocks.
// Reading and writing the same address on the same edge returns stale data.
module simple_dual_ram #(
  parameter int unsigned SIZE  = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     wclk,
  input  logic                     rclk,
  input  logic                     write_en,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [SIZE-1:0]          write_data,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [SIZE-1:0]          read_data
);
  logic [SIZE-1:0] mem [DEPTH];

  always_ff @(posedge wclk) begin
    if (write_en) mem[waddr] <= write_data;
  end

  always_ff @(posedge rclk) begin
    read_data <= mem[raddr];
  end
endmodule

// File: rtl/ram_fifo_ctrl.sv
// First-word-fall-through FIFO around a simple_dual_ram with a one-entry collision bypass.
// Optional occupancy output `level` is enabled by defining RAM_FIFO_LEVEL_EN.
module ram_fifo_ctrl #(
  parameter int unsigned SIZE  = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  ram_fifo_ctrl_if.slave         bus
`ifdef RAM_FIFO_LEVEL_EN
  ,
  output logic [$clog2(DEPTH):0] level
`endif
);
  localparam int unsigned ADDR_W = $clog2(DEPTH);

  logic [ADDR_W:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic [ADDR_W-1:0] waddr, raddr;
  logic              empty, full, push, pop;
  logic [SIZE-1:0]   ram_rdata, byp_data_q;
  logic              byp_sel_q;

  always_comb begin
    empty         = (wptr_q == rptr_q);
    full          = (wptr_q[ADDR_W-1:0] == rptr_q[ADDR_W-1:0]) &&
                    (wptr_q[ADDR_W] != rptr_q[ADDR_W]);
    bus.wr_ready  = !full && !rst;
    bus.rd_valid  = !empty;
    push          = bus.wr_valid && bus.wr_ready;
    pop           = bus.rd_valid && bus.rd_ready;
    wptr_d        = wptr_q + {{ADDR_W{1'b0}}, push};
    rptr_d        = rptr_q + {{ADDR_W{1'b0}}, pop};
    waddr         = wptr_q[ADDR_W-1:0];
    // Address the post-pop head so the RAM output is the new head one cycle later.
    raddr         = rptr_d[ADDR_W-1:0];
    bus.rd_data   = byp_sel_q ? byp_data_q : ram_rdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      byp_sel_q  <= 1'b0;
      byp_data_q <= '0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      // Same-address write/read only happens when the FIFO is or becomes empty.
      byp_sel_q  <= push && (waddr == raddr);
      byp_data_q <= bus.wr_data;
    end
  end

`ifdef RAM_FIFO_LEVEL_EN
  assign level = wptr_q - rptr_q;
`endif

  simple_dual_ram #(
    .SIZE  (SIZE),
    .DEPTH (DEPTH)
  ) u_ram (
    .wclk       (clk),
    .rclk       (clk),
    .write_en   (push),
    .waddr      (waddr),
    .write_data (bus.wr_data),
    .raddr      (raddr),
    .read_data  (ram_rdata)
  );
endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Self-checking bench for ram_fifo_ctrl: directed scenarios plus random traffic
// compared against a queue-based FIFO model.
module tb_ram_fifo_ctrl;
  localparam int SIZE  = 8;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;
  logic [SIZE-1:0] q[$];

  ram_fifo_ctrl_if #(.SIZE(SIZE)) bus ();

`ifdef RAM_FIFO_LEVEL_EN
  logic [$clog2(DEPTH):0] level;
  ram_fifo_ctrl #(.SIZE(SIZE), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus),
    .level (level)
  );
`else
  ram_fifo_ctrl #(.SIZE(SIZE), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );
`endif

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h at %0t", tag, obs, expv, $time);
    end
  endtask

  task automatic check_outputs();
    check("rd_valid", {31'd0, bus.rd_valid}, {31'd0, q.size() != 0});
    check("wr_ready", {31'd0, bus.wr_ready}, {31'd0, (q.size() < DEPTH) && !rst});
    if (q.size() != 0) check("rd_data", {24'd0, bus.rd_data}, {24'd0, q[0]});
`ifdef RAM_FIFO_LEVEL_EN
    check("level", {28'd0, level}, q.size());
`endif
  endtask

  // Apply one cycle of inputs, advance the model by the FIFO rules, then compare.
  task automatic step(input logic wv, input logic [SIZE-1:0] wd, input logic rr);
    logic do_push, do_pop;
    bus.wr_valid = wv;
    bus.wr_data  = wd;
    bus.rd_ready = rr;
    do_push = wv && (q.size() < DEPTH);
    do_pop  = rr && (q.size() != 0);
    @(posedge clk);
    if (do_pop) void'(q.pop_front());
    if (do_push) q.push_back(wd);
    #1;
    check_outputs();
  endtask

  initial begin
    bus.wr_valid = 1'b0;
    bus.wr_data  = '0;
    bus.rd_ready = 1'b0;
    #1;
    check("rst_rd_valid", {31'd0, bus.rd_valid}, 32'd0);
    check("rst_wr_ready", {31'd0, bus.wr_ready}, 32'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1 check_outputs();

    // Single push into empty FIFO, held while consumer stalls.
    step(1'b1, 8'h11, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    step(1'b0, 8'h00, 1'b1);

    // Fill to capacity, offer a ninth word, then drain.
    for (int i = 1; i <= 8; i++) step(1'b1, i[7:0], 1'b0);
    step(1'b1, 8'h09, 1'b0);
    for (int i = 0; i < 9; i++) step(1'b0, 8'h00, 1'b1);

    // One entry, then simultaneous push and pop through the bypass.
    step(1'b1, 8'hA0, 1'b0);
    step(1'b1, 8'hB0, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b1);

    // Streaming: one push and one pop every cycle across pointer wraps.
    step(1'b1, 8'd1, 1'b0);
    for (int i = 2; i <= 20; i++) step(1'b1, i[7:0], 1'b1);
    step(1'b0, 8'h00, 1'b1);

    // Full with a pop: the slot frees only on the next cycle.
    for (int i = 0; i < 8; i++) step(1'b1, 8'hC0 + i[7:0], 1'b0);
    step(1'b1, 8'hEE, 1'b1);
    step(1'b1, 8'hEF, 1'b0);
    for (int i = 0; i < 9; i++) step(1'b0, 8'h00, 1'b1);

    // Asynchronous reset with 5 entries stored.
    for (int i = 0; i < 5; i++) step(1'b1, 8'h30 + i[7:0], 1'b0);
    #2 rst = 1'b1;
    #1;
    check("async_rd_valid", {31'd0, bus.rd_valid}, 32'd0);
    check("async_wr_ready", {31'd0, bus.wr_ready}, 32'd0);
    q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    #1 check_outputs();
    step(1'b1, 8'h55, 1'b0);
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b1);

    // Random traffic with varying producer/consumer duty.
    for (int i = 0; i < 600; i++) begin
      int unsigned wbias, rbias;
      wbias = (i < 200) ? 80 : (i < 400) ? 30 : 55;
      rbias = (i < 200) ? 30 : (i < 400) ? 80 : 55;
      step($urandom_range(99) < wbias, 8'($urandom), $urandom_range(99) < rbias);
    end
    for (int i = 0; i < DEPTH + 1; i++) step(1'b0, 8'h00, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/ram_fifo_ctrl.md
Name: ram_fifo_ctrl

Overview:
- Synchronous first-word-fall-through FIFO built around one simple_dual_ram instance, with both RAM clocks tied to clk.
- Sequences the RAM's write and read ports from valid/ready handshakes and keeps per-entry state only in the RAM.
- Resolves the RAM's undefined same-address read/write case with a one-entry bypass register.
- Standard buffering stage between streaming producers and consumers, e.g. UART/ALU result queues.

Parameters:
- SIZE, 8, width of each stored word.
- DEPTH, 8, number of entries; must be a power of two and at least 2. Capacity is exactly DEPTH.

Ports:
- clk  input  1  system clock
- rst  input  1  reset, asynchronous, active-high
- wr_data  input  SIZE  word to enqueue
- wr_valid  input  1  producer offers wr_data
- wr_ready  output  1  FIFO can accept a word; equals !full && !rst
- rd_data  output  SIZE  head word; only meaningful while rd_valid=1
- rd_valid  output  1  head word is present; equals !empty
- rd_ready  input  1  consumer takes the head word

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-high.
- Pointers: wptr and rptr, each $clog2(DEPTH)+1 bits, with an extra wrap bit; reset to 0.
- Status: empty = (wptr==rptr). full = low address bits equal and wrap bits differ. Both are combinational from registered pointers.
- Push = wr_valid && wr_ready. On push: RAM write_en=1, waddr=wptr[low], write_data=wr_data; wptr increments at the clock edge.
- Pop = rd_valid && rd_ready. On pop: rptr increments.
- Read address: RAM raddr = rptr_next[low], where rptr_next = rptr + pop. This is combinational, so RAM read_data shows the new head one cycle after each pointer update (FWFT).
- Bypass: register byp_sel <= push && (waddr == raddr); byp_data <= wr_data. rd_data = byp_sel ? byp_data : RAM read_data. A collision only occurs when the FIFO is, or becomes, empty in that cycle.
- Latency: word pushed at edge t gives rd_valid=1 and the correct rd_data in the cycle after edge t (1 cycle).
- Throughput: one push and one pop per cycle sustained.
- Full + push attempt: wr_ready=0 and the word is dropped by the producer's protocol. A simultaneous pop frees the slot only for the next cycle.
- Empty + rd_ready: no pop, pointers unchanged, rd_valid stays 0.
- Single entry with push and pop in the same cycle: the collision path is taken and the next head comes from the bypass.
- Pointer wrap: the wrap bit toggles on each lap. There is no count overflow; occupancy = wptr - rptr, modulo 2^(ADDR_W+1).
- Reset mid-operation: all contents are discarded. Pointers and byp_sel go to 0 immediately. rd_valid=0, and wr_ready=0 while rst is high, then 1.
- Reset values: wr_ready=0 during rst; rd_valid=0; rd_data is don't-care.

Optional Feature:
- Macro RAM_FIFO_LEVEL_EN.
- Defined: adds output port level [$clog2(DEPTH):0] = wptr - rptr, registered-pointer based, range 0..DEPTH, reset 0. It updates in the same cycle the pointers change.
- Undefined: the port is absent and there is no subtractor.

Decomposition:
- No shared package.
- Local constant ADDR_W = $clog2(DEPTH) inside the module.
- One sub-module: simple_dual_ram instance (SIZE, DEPTH passed through). Pointer logic, status flags and the bypass stay in this module.

Test Plan (SIZE=8, DEPTH=8):
- Reset then idle -> rd_valid=0, wr_ready=1 in the first cycle after rst falls; pointers 0.
- Push 0x11 into empty FIFO, rd_ready=0 -> the next cycle shows rd_valid=1 and rd_data=0x11 (bypass path); it holds until rd_ready.
- Push 8 words 0x01..0x08 with rd_ready=0 -> wr_ready=0 after the 8th push; a 9th offer of 0x09 is not accepted. Draining yields 0x01..0x08 in order, then rd_valid=0.
- Fill to 1 entry (0xA0), then in one cycle push 0xB0 and pop -> next cycle rd_data=0xB0 via bypass, rd_valid=1. The cycle after a pop, rd_valid=0.
- Continuous push and pop of 20 incrementing words -> output sequence identical, no bubbles after the first, pointers wrap twice. With RAM_FIFO_LEVEL_EN, level stays at 1.
- Assert rst with 5 entries stored -> rd_valid=0 and wr_ready=0 asynchronously. After release, push 0x55 -> 0x55 is the only word read back.
